uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_receiver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a consumer-side buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_receiver #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun
);
  localparam int DIV   = comm_clk_frequency / baud_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift;
  logic             r_rx_meta, r_rx_s, r_rx_prev;
  logic             r_ferr, r_ovr;
  logic             w_fall, w_shift_en, w_push, w_ferr, w_pop, w_wr;

  assign w_fall      = r_rx_prev & ~r_rx_s;
  assign frame_error = r_ferr;
  assign overrun     = r_ovr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_ferr    <= w_ferr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift[r_idx] <= r_rx_s;
  end

  // Stop-bit low returns to IDLE with rx_s low, so a fresh falling edge is needed to restart.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          w_idx_nxt  = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_push      = r_rx_s;
          w_ferr      = ~r_rx_s;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_count;

  assign rx_valid = (r_count != 3'd0);
  assign rx_byte  = r_mem[r_rp];
  assign w_pop    = rx_ack & rx_valid;
  assign w_wr     = w_push & ((r_count != 3'd4) | w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_push & ~w_wr;
      if (w_wr) begin
        r_mem[r_wp] <= r_shift;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign rx_valid = r_valid;
  assign rx_byte  = r_hold;
  assign w_pop    = rx_ack & r_valid;
  assign w_wr     = w_push & (~r_valid | w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_push & ~w_wr;
      if (w_wr) begin
        r_hold  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV=16; received bytes are checked against a scoreboard queue.
module tb_uart_receiver;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_error;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  logic [7:0] q [$];

  uart_receiver #(
    .comm_clk_frequency(1_600_000),
    .baud_rate         (100_000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun)     ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame starts at the current negedge; each bit lasts 16 cycles; 160 cycles total.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int ack_at,
                            input int rst_at, output int rise_at);
    logic       seen;
    logic [8:0] exp9;
    seen    = rx_valid;
    rise_at = -1;
    for (int i = 0; i < 160; i++) begin
      int k;
      k = i / 16;
      if (k == 0)      uart_rx = 1'b0;
      else if (k == 9) uart_rx = stop_b;
      else             uart_rx = b[k-1];
      reset  = (i == rst_at) ? 1'b0 : 1'b1;
      rx_ack = 1'b0;
      if (i == ack_at) begin
        exp9 = (q.size() > 0) ? {1'b0, q.pop_front()} : 9'h100;
        check("ack_byte", 32'({1'b0, rx_byte}), 32'(exp9));
        rx_ack = 1'b1;
      end
      @(negedge clk);
      if (i == rst_at) begin
        check("rst_mid_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_byte", 32'(rx_byte), 32'h00);
        check("rst_mid_ferr", 32'(frame_error), 32'd0);
        check("rst_mid_ovr", 32'(overrun), 32'd0);
      end
      if (!seen && rx_valid && rise_at < 0) rise_at = i + 1;
      seen = rx_valid;
    end
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] exp9;
    exp9 = (q.size() > 0) ? {1'b0, q.pop_front()} : 9'h100;
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_byte"}, 32'({1'b0, rx_byte}), 32'(exp9));
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check({tag, "_after"}, 32'(rx_valid), 32'(q.size() > 0));
  endtask

  initial begin
    int         r;
    int         fe0, ov0;
    logic [7:0] v;

    reset   = 1'b0;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_byte", 32'(rx_byte), 32'h00);
    check("reset_ferr", 32'(frame_error), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Basic byte with push latency measured from the start edge.
    q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, r);
    check("a5_rise_cycle", 32'(r), 32'd155);
    pop_check("a5");

    // Ack on an empty buffer must not disturb occupancy.
    rx_ack = 1'b1;
    repeat (2) @(negedge clk);
    rx_ack = 1'b0;
    check("ack_empty_valid", 32'(rx_valid), 32'd0);
    q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1, -1, r);
    pop_check("b42");

    // Short low glitch is rejected.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
    q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -1, -1, r);
    pop_check("after_glitch");

    // Low stop bit: one frame_error pulse, nothing pushed.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, -1, r);
    repeat (20) @(negedge clk);
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_valid", 32'(rx_valid), 32'd0);
    q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1, r);
    pop_check("b81");

    // Overrun: one byte beyond capacity is dropped.
    ov0 = ov_cnt;
    for (int j = 0; j <= DEPTH; j++) begin
      v = (DEPTH == 1) ? 8'(8'h11 * (j + 1)) : 8'(j + 1);
      if (j < DEPTH) q.push_back(v);
      send_frame(v, 1'b1, -1, -1, r);
    end
    repeat (4) @(negedge clk);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    for (int j = 0; j < DEPTH; j++) pop_check("ovr_pop");

    // Full buffer with ack on the push cycle: both succeed.
    ov0 = ov_cnt;
    for (int j = 0; j < DEPTH; j++) begin
      v = 8'(8'h70 + j);
      q.push_back(v);
      send_frame(v, 1'b1, -1, -1, r);
    end
    q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 154, -1, r);
    repeat (4) @(negedge clk);
    check("ackpush_ovr", 32'(ov_cnt - ov0), 32'd0);
    for (int j = 0; j < DEPTH; j++) pop_check("ackpush_pop");

    // Reset during data bit 3 clears the buffer and abandons the frame.
    q.push_back(8'h66);
    send_frame(8'h66, 1'b1, -1, -1, r);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hF8, 1'b1, -1, 66, r);
    q.delete();
    repeat (10) @(negedge clk);
    check("rst_no_push", 32'(r), 32'hFFFF_FFFF);
    check("rst_valid_after", 32'(rx_valid), 32'd0);
    check("rst_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1, r);
    pop_check("b5a");

    repeat (5) @(negedge clk);
    check("total_ferr", 32'(fe_cnt), 32'd1);
    check("total_ovr", 32'(ov_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
